execute_stage_mdu: RTL
======================

# execute_stage_mdu

Execute stage with an integrated multi-cycle multiply/divide unit (RV32M/RV64M), parametrised in XLEN and multiplier latency. It sits between the ID/EX and EX/MEM boundaries. It keeps the existing forwarding, AUIPC and ALU-source muxing and the E/M pipeline register. It adds an MDU state machine that stalls the front of the pipeline while a MUL/DIV/REM instruction is in progress. Branch resolution stays in Decode. The JALR target is still produced here.

## Interface
- XLEN, 32, datapath width (32 or 64)
- MUL_LATENCY, 2, cycles from multiply start to the DONE state (≥1)
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush_e  in  1  kill the E-stage instruction and abort the MDU
- reg_write_e, mem_write_e, alu_src_e, alu_src_a_e  in  1 each  decoded controls
- result_src_e  in  2  writeback source select
- alu_control_e  in  4  ALU operation
- mdu_en_e  in  1  instruction in E is an M-extension op
- mdu_op_e  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000–111)
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  in  XLEN each  operands
- rd_e  in  5  destination register
- result_w  in  XLEN  writeback forward value
- forward_a_e, forward_b_e  in  2 each  00 = RF, 01 = W, 10 = M, 11 = zero
- stall_e  out  1  hold PC, F/D and D/E registers
- pc_target_e  out  XLEN  ALU result (JALR target)
- reg_write_m, mem_write_m  out  1 each  registered
- result_src_m  out  2  registered
- rd_m  out  5  registered
- pc_plus4_m, write_data_m, alu_result_m  out  XLEN each  registered

## Operation
- **Forwarding and ALU path:** forwarding, AUIPC mux, ALU-source mux and ALU behave as in the single-cycle execute stage. write_data_m takes the forwarded B operand, never the immediate.
- **MDU state machine:** states IDLE, MUL, DIV, DONE.
- **IDLE:**
  - If mdu_en_e and not flush_e, latch the forwarded A/B and mdu_op.
  - Multiply goes to MUL, or straight to DONE when MUL_LATENCY = 1.
  - Divide goes to DIV.
  - Divide by zero and signed overflow go straight to DONE.
- **MUL:** counts MUL_LATENCY−1 cycles, then goes to DONE.
- **DIV:** radix-2 restoring division on magnitudes, one quotient bit per cycle for XLEN cycles, then sign fix-up and DONE.
- **DONE:** result selected into the E/M register, then return to IDLE.
- Operands are latched at start, because the M/W forward sources change while the stage is stalled.
- **Multiply:** 2·XLEN-bit product of the (XLEN+1)-bit sign/zero-extended operands.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands.
- **Special divide cases:**
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN, remainder 0.
  - DIVU/REMU take no sign fix-up.
- **stall_e** = mdu_en_e && state ≠ DONE && !flush_e, forced to 0 while reset is high.
- **While stall_e is high:** the E/M register loads a bubble: reg_write_m = 0, mem_write_m = 0, rd_m = 0, other fields don't-care.
- **flush_e:** forces state to IDLE and loads a bubble, in any state. It has priority over start and completion.
- **Reset:** every registered output is 0 and the state is IDLE.
- **Reset mid-operation:** abandons the op. No result is written.

## Timing
- Non-MDU instructions: 1 cycle in E, and stall_e stays low.
- Multiply: E occupancy is MUL_LATENCY+1 cycles. stall_e is high for the first MUL_LATENCY of them.
- Divide/remainder: occupancy XLEN+2 (start, XLEN iterations, DONE).
- Divide by zero and overflow: occupancy 2.
- The result is visible on alu_result_m in the cycle after DONE.
- An MDU op entering E back-to-back after a completed one starts in the cycle after DONE. No idle cycle is inserted.
- pc_target_e is combinational from the current operands.

## Structure
- **Shared package exec_pkg:**
  - mdu_op_t enum (funct3 encoding)
  - ALU control constants
  - forward-select encoding
  - mdu_state_t
- **Sub-module mdu_unit:** FSM, latched operands, multiplier, iterative divider, special-case detection.
  - Inputs: start, op, a, b, abort.
  - Outputs: busy, done, result.
- The top level instantiates the existing ALU and mux modules plus mdu_unit, and owns the E/M register.

## Test plan
- **Plain ADD:** ADD with rd1 = 5, rd2 = 7, no forwarding → alu_result_m = 12 next cycle; stall_e never asserted.
- **MULH with W forwarding:** MULH, a = 0x80000000, b = 2, forward_a = 01 with result_w changing during the stall, MUL_LATENCY = 2 → stall_e high 2 cycles; alu_result_m = 0xFFFFFFFF; operand latched at start.
- **Signed DIV/REM:** DIV −7 / 2 → quotient −3 after XLEN+2 cycles; REM −7 / 2 → −1; reg_write_m = 0 during all stall cycles.
- **Divide special cases:**
  - DIVU 9 / 0 → 0xFFFFFFFF.
  - REM 9 / 0 → 9.
  - DIV 0x80000000 / −1 → 0x80000000.
  - Each with occupancy 2.
- **Abort:** flush_e or async reset asserted mid-DIV (iteration 10) → state IDLE, stall_e low, bubble in M; the next DIV completes correctly.
- **XLEN = 64:** MULHU 0xFFFF…FF × 0xFFFF…FF → 0xFFFF…FE; DIVU latency 66 cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute stage and its multiply/divide unit
//   mdu_op_t    : M-extension funct3 encoding
//   mdu_state_t : MDU sequencer states
//   fwd_sel_t   : operand forwarding select (RF, W, M, zero)
//   ALU_*       : ALU control codes
package exec_pkg;
  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;
  typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_M, FWD_ZERO} fwd_sel_t;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide sequencer for RV32M/RV64M
//   clock, reset : clock, asynchronous active-high reset
//   i_start      : begin an operation (only honoured in IDLE)
//   i_op         : funct3 of the M-extension op
//   i_a, i_b     : operands, latched at start
//   i_abort      : return to IDLE from any state, overrides start
//   o_busy       : an operation is held (state not IDLE)
//   o_done       : result valid this cycle (state DONE)
//   o_result     : selected product half, quotient or remainder
module mdu_unit
  import exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_abort,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN + MUL_LATENCY + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_t      r_state;
  mdu_op_t         r_op;
  logic [XLEN-1:0] r_a, r_b, r_quo, r_rem, r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            w_div, w_sdiv, w_special;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic            w_sa, w_sb, w_rsdiv, w_neg_q, w_neg_r, w_rovf;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0] w_q, w_r;
  assign w_div     = i_op[2];
  assign w_sdiv    = i_op[2] && !i_op[0];
  assign w_special = (i_b == '0) || (w_sdiv && i_a == MIN && i_b == '1);
  assign w_a_mag   = (w_sdiv && i_a[XLEN-1]) ? -i_a : i_a;
  assign w_b_mag   = (w_sdiv && i_b[XLEN-1]) ? -i_b : i_b;
  // Restoring step: shift the next dividend bit into the partial remainder
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  // Low 2*XLEN bits of the sign/zero-extended product are exact for every variant
  assign w_sa   = (r_op == MDU_MULH || r_op == MDU_MULHSU) && r_a[XLEN-1];
  assign w_sb   = (r_op == MDU_MULH) && r_b[XLEN-1];
  assign w_ma   = {{XLEN{w_sa}}, r_a};
  assign w_mb   = {{XLEN{w_sb}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_rsdiv = !r_op[0];
  assign w_rovf  = w_rsdiv && r_a == MIN && r_b == '1;
  assign w_neg_q = w_rsdiv && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_neg_r = w_rsdiv && r_a[XLEN-1];
  assign w_q = (r_b == '0) ? '1 : w_rovf ? MIN : w_neg_q ? -r_quo : r_quo;
  assign w_r = (r_b == '0) ? r_a : w_rovf ? '0 : w_neg_r ? -r_rem : r_rem;
  assign o_result = r_op[2] ? (r_op[1] ? w_r : w_q)
                  : (r_op == MDU_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_state == S_DONE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= MDU_MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op    <= mdu_op_t'(i_op);
          r_a     <= i_a;
          r_b     <= i_b;
          r_quo   <= w_a_mag;
          r_rem   <= '0;
          r_dvs   <= w_b_mag;
          r_cnt   <= w_div ? CW'(XLEN - 1) : CW'(MUL_LATENCY - 2);
          r_state <= w_div ? (w_special ? S_DONE : S_DIV)
                   : (MUL_LATENCY == 1 ? S_DONE : S_MUL);
        end
        S_MUL: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_DONE;
        end
        S_DIV: begin
          r_rem <= w_ge ? XLEN'(w_shift - {1'b0, r_dvs}) : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: execute stage with forwarding, ALU and a multi-cycle MDU
//   clock, reset        : clock, asynchronous active-high reset
//   i_flush_e           : kill the E instruction and abort the MDU
//   i_*_e controls      : decoded controls, mdu enable and funct3
//   i_rd1/rd2/imm/pc_e  : operands; i_result_w is the W forward value
//   i_forward_a/b_e     : 00 RF, 01 W, 10 M, 11 zero
//   o_stall_e           : hold PC, F/D and D/E while an MDU op is in progress
//   o_pc_target_e       : combinational ALU result (JALR target)
//   o_*_m               : E/M pipeline register
module execute_stage_mdu
  import exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush_e,
  input  logic            i_reg_write_e,
  input  logic            i_mem_write_e,
  input  logic            i_alu_src_e,
  input  logic            i_alu_src_a_e,
  input  logic [1:0]      i_result_src_e,
  input  logic [3:0]      i_alu_control_e,
  input  logic            i_mdu_en_e,
  input  logic [2:0]      i_mdu_op_e,
  input  logic [XLEN-1:0] i_rd1_e,
  input  logic [XLEN-1:0] i_rd2_e,
  input  logic [XLEN-1:0] i_imm_ext_e,
  input  logic [XLEN-1:0] i_pc_e,
  input  logic [XLEN-1:0] i_pc_plus4_e,
  input  logic [4:0]      i_rd_e,
  input  logic [XLEN-1:0] i_result_w,
  input  logic [1:0]      i_forward_a_e,
  input  logic [1:0]      i_forward_b_e,
  output logic            o_stall_e,
  output logic [XLEN-1:0] o_pc_target_e,
  output logic            o_reg_write_m,
  output logic            o_mem_write_m,
  output logic [1:0]      o_result_src_m,
  output logic [4:0]      o_rd_m,
  output logic [XLEN-1:0] o_pc_plus4_m,
  output logic [XLEN-1:0] o_write_data_m,
  output logic [XLEN-1:0] o_alu_result_m
);
  localparam int SW = $clog2(XLEN);
  logic            r_reg_write_m, r_mem_write_m;
  logic [1:0]      r_result_src_m;
  logic [4:0]      r_rd_m;
  logic [XLEN-1:0] r_pc_plus4_m, r_write_data_m, r_alu_result_m;
  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu, w_mdu_result;
  logic [SW-1:0]   w_shamt;
  logic            w_mdu_busy, w_mdu_done, w_stall;
  assign w_fwd_a = i_forward_a_e == FWD_W ? i_result_w : i_forward_a_e == FWD_M ? r_alu_result_m
                 : i_forward_a_e == FWD_ZERO ? '0 : i_rd1_e;
  assign w_fwd_b = i_forward_b_e == FWD_W ? i_result_w : i_forward_b_e == FWD_M ? r_alu_result_m
                 : i_forward_b_e == FWD_ZERO ? '0 : i_rd2_e;
  assign w_src_a = i_alu_src_a_e ? i_pc_e : w_fwd_a;
  assign w_src_b = i_alu_src_e ? i_imm_ext_e : w_fwd_b;
  assign w_shamt = w_src_b[SW-1:0];
  always_comb begin
    w_alu = w_src_a + w_src_b;
    case (i_alu_control_e)
      ALU_SUB:  w_alu = w_src_a - w_src_b;
      ALU_AND:  w_alu = w_src_a & w_src_b;
      ALU_OR:   w_alu = w_src_a | w_src_b;
      ALU_XOR:  w_alu = w_src_a ^ w_src_b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
      ALU_SLL:  w_alu = w_src_a << w_shamt;
      ALU_SRL:  w_alu = w_src_a >> w_shamt;
      ALU_SRA:  w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
      default:  w_alu = w_src_a + w_src_b;
    endcase
  end
  // The MDU takes forwarded operands (not the AUIPC/immediate muxes) and latches them
  mdu_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) u_mdu (
    .clock    (clock),
    .reset    (reset),
    .i_start  (i_mdu_en_e && !i_flush_e),
    .i_op     (i_mdu_op_e),
    .i_a      (w_fwd_a),
    .i_b      (w_fwd_b),
    .i_abort  (i_flush_e),
    .o_busy   (w_mdu_busy),
    .o_done   (w_mdu_done),
    .o_result (w_mdu_result)
  );
  assign w_stall       = i_mdu_en_e && !w_mdu_done && !i_flush_e && !reset;
  assign o_stall_e     = w_stall;
  assign o_pc_target_e = w_alu;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
      r_rd_m         <= '0;
      r_pc_plus4_m   <= '0;
      r_write_data_m <= '0;
      r_alu_result_m <= '0;
    end else if (w_stall || i_flush_e) begin
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_rd_m        <= '0;
    end else begin
      r_reg_write_m  <= i_reg_write_e;
      r_mem_write_m  <= i_mem_write_e;
      r_result_src_m <= i_result_src_e;
      r_rd_m         <= i_rd_e;
      r_pc_plus4_m   <= i_pc_plus4_e;
      r_write_data_m <= w_fwd_b;
      r_alu_result_m <= (i_mdu_en_e && w_mdu_busy) ? w_mdu_result : w_alu;
    end
  end
  assign o_reg_write_m  = r_reg_write_m;
  assign o_mem_write_m  = r_mem_write_m;
  assign o_result_src_m = r_result_src_m;
  assign o_rd_m         = r_rd_m;
  assign o_pc_plus4_m   = r_pc_plus4_m;
  assign o_write_data_m = r_write_data_m;
  assign o_alu_result_m = r_alu_result_m;
endmodule
